// File: rtl/store_commit_unit.sv
// Store-commit responder: latches one committed store from the ROB and serialises it
// into little-endian byte writes on the shared 8-bit RAM port, then pulses finish_store.
module store_commit_unit #(
  parameter int unsigned       ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0003_0000),
  parameter logic [4:0]        OP_SB   = 5'd16,
  parameter logic [4:0]        OP_SH   = 5'd17,
  parameter logic [4:0]        OP_SW   = 5'd18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              rob_store_sgn,
  input  logic [4:0]        rob_store_op,
  input  logic [31:0]       rob_store_addr,
  input  logic [31:0]       rob_store_data,
  output logic              finish_store,
  output logic              busy,
  output logic              bad_op,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          k_q, k_d;
  logic [2:0]          len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                finish_q, finish_d;
  logic                busy_q, busy_d;
  logic                bad_op_q, bad_op_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;

  logic                op_valid;
  logic [2:0]          op_len;
  logic [ADDR_W-1:0]   cur_addr;
  logic [7:0]          cur_byte;
  logic                io_stall;

  always_comb begin
    op_valid = 1'b1;
    op_len   = 3'd1;
    case (rob_store_op)
      OP_SB:   op_len = 3'd1;
      OP_SH:   op_len = 3'd2;
      OP_SW:   op_len = 3'd4;
      default: op_valid = 1'b0;
    endcase
  end

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign cur_addr = addr_q + ADDR_W'(k_q);
  assign cur_byte = data_q[{k_q[1:0], 3'b000} +: 8];
  assign io_stall = (cur_addr >= IO_BASE) && io_buffer_full;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    len_d      = len_q;
    addr_d     = addr_q;
    data_d     = data_q;
    finish_d   = finish_q;
    busy_d     = busy_q;
    bad_op_d   = bad_op_q;
    mem_req_d  = mem_req_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;

    if (rdy) begin
      finish_d = 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            finish_d  = 1'b1;
            busy_d    = 1'b1;
          end else begin
            busy_d    = 1'b0;
          end
          mem_req_d = 1'b0;
          state_d   = IDLE;
          // DONE accepts a new store exactly like IDLE so stores can run back-to-back.
          if (rob_store_sgn) begin
            addr_d = ADDR_W'(rob_store_addr);
            data_d = rob_store_data;
            k_d    = 3'd0;
            busy_d = 1'b1;
            if (op_valid) begin
              len_d     = op_len;
              mem_req_d = 1'b1;
              state_d   = WAIT_GNT;
            end else begin
              bad_op_d  = 1'b1;
              state_d   = DONE;
            end
          end
        end
        WAIT_GNT, WRITE: begin
          if (mem_gnt) begin
            state_d = WRITE;
            if (!io_stall) begin
              mem_wr_d   = 1'b1;
              mem_a_d    = cur_addr;
              mem_dout_d = cur_byte;
              k_d        = k_q + 3'd1;
              if (k_q == len_q - 3'd1) begin
                state_d = DONE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      k_q        <= 3'd0;
      len_q      <= 3'd0;
      addr_q     <= '0;
      data_q     <= '0;
      finish_q   <= 1'b0;
      busy_q     <= 1'b0;
      bad_op_q   <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      finish_q   <= finish_d;
      busy_q     <= busy_d;
      bad_op_q   <= bad_op_d;
      mem_req_q  <= mem_req_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
    end
  end

  assign finish_store = finish_q;
  assign busy         = busy_q;
  assign bad_op       = bad_op_q;
  assign mem_req      = mem_req_q;
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q;

endmodule

// File: tb/tb_store_commit_unit.sv
// Directed bench for store_commit_unit: byte serialisation, IO stalls, grant loss,
// back-to-back stores, bad opcodes and asynchronous reset mid-store.
module tb_store_commit_unit;

  localparam logic [4:0] SB = 5'd16;
  localparam logic [4:0] SH = 5'd17;
  localparam logic [4:0] SW = 5'd18;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rob_store_sgn;
  logic [4:0]  rob_store_op;
  logic [31:0] rob_store_addr;
  logic [31:0] rob_store_data;
  logic        finish_store;
  logic        busy;
  logic        bad_op;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic        io_buffer_full;

  int total;
  int bad;

  store_commit_unit #(
    .ADDR_W (32),
    .IO_BASE(32'h0003_0000),
    .OP_SB  (SB),
    .OP_SH  (SH),
    .OP_SW  (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .rob_store_sgn (rob_store_sgn),
    .rob_store_op  (rob_store_op),
    .rob_store_addr(rob_store_addr),
    .rob_store_data(rob_store_data),
    .finish_store  (finish_store),
    .busy          (busy),
    .bad_op        (bad_op),
    .mem_req       (mem_req),
    .mem_gnt       (mem_gnt),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .mem_wr        (mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One line per observed cycle: write strobe/address/data plus handshake outputs.
  task automatic expect_cycle(input string tag, input logic wr, input logic [31:0] a,
                              input logic [7:0] d, input logic req, input logic fin,
                              input logic bsy);
    $display("%0t %s: wr=%0b a=%08h d=%02h req=%0b fin=%0b busy=%0b",
             $time, tag, mem_wr, mem_a, mem_dout, mem_req, finish_store, busy);
    chk({tag, ".wr"}, {63'd0, mem_wr}, {63'd0, wr});
    if (wr) begin
      chk({tag, ".a"}, {32'd0, mem_a}, {32'd0, a});
      chk({tag, ".d"}, {56'd0, mem_dout}, {56'd0, d});
    end
    chk({tag, ".req"}, {63'd0, mem_req}, {63'd0, req});
    chk({tag, ".fin"}, {63'd0, finish_store}, {63'd0, fin});
    chk({tag, ".busy"}, {63'd0, busy}, {63'd0, bsy});
  endtask

  task automatic pulse_store(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d);
    rob_store_sgn  = 1'b1;
    rob_store_op   = op;
    rob_store_addr = a;
    rob_store_data = d;
    cyc();
    rob_store_sgn  = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    rdy = 1'b1;
    rob_store_sgn = 1'b0;
    rob_store_op = 5'd0;
    rob_store_addr = 32'd0;
    rob_store_data = 32'd0;
    mem_gnt = 1'b1;
    io_buffer_full = 1'b0;

    cyc();
    cyc();
    expect_cycle("reset", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("reset.a", {32'd0, mem_a}, 64'd0);
    chk("reset.d", {56'd0, mem_dout}, 64'd0);
    chk("reset.bad_op", {63'd0, bad_op}, 64'd0);
    rst = 1'b1;
    cyc();

    // SW with grant tied high: four consecutive bytes, finish 5 cycles after mem_req.
    pulse_store(SW, 32'h0000_0100, 32'hDEAD_BEEF);
    expect_cycle("sw.req", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("sw.b0", 1'b1, 32'h100, 8'hEF, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("sw.b1", 1'b1, 32'h101, 8'hBE, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("sw.b2", 1'b1, 32'h102, 8'hAD, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("sw.b3", 1'b1, 32'h103, 8'hDE, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("sw.fin", 1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    cyc(); expect_cycle("sw.idle", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // SB into IO space with the IO sink full for three cycles.
    io_buffer_full = 1'b1;
    pulse_store(SB, 32'h0003_0000, 32'h0000_0041);
    expect_cycle("io.req", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("io.stall0", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("io.stall1", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("io.stall2", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    io_buffer_full = 1'b0;
    cyc(); expect_cycle("io.b0", 1'b1, 32'h0003_0000, 8'h41, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("io.fin", 1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    cyc(); expect_cycle("io.idle", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // SH at the top of the address space with a two-cycle grant loss; address wraps to 0.
    pulse_store(SH, 32'hFFFF_FFFF, 32'h0000_1234);
    expect_cycle("sh.req", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("sh.b0", 1'b1, 32'hFFFF_FFFF, 8'h34, 1'b1, 1'b0, 1'b1);
    mem_gnt = 1'b0;
    cyc(); expect_cycle("sh.nognt0", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("sh.nognt1", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    mem_gnt = 1'b1;
    cyc(); expect_cycle("sh.b1", 1'b1, 32'h0000_0000, 8'h12, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("sh.fin", 1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    cyc();

    // Back-to-back: SB pulsed in the SW's finish_store cycle.
    pulse_store(SW, 32'h0000_0200, 32'h1122_3344);
    cyc(); expect_cycle("b2b.w0", 1'b1, 32'h200, 8'h44, 1'b1, 1'b0, 1'b1);
    cyc(); cyc();
    cyc(); expect_cycle("b2b.w3", 1'b1, 32'h203, 8'h11, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("b2b.fin", 1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    pulse_store(SB, 32'h0000_0300, 32'h0000_00AB);
    expect_cycle("b2b.req2", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("b2b.sb", 1'b1, 32'h300, 8'hAB, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("b2b.fin2", 1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    cyc();

    // Unknown opcode: sticky bad_op, no writes, finish one cycle after latch.
    pulse_store(5'h1F, 32'h0000_0600, 32'hFFFF_FFFF);
    expect_cycle("badop.latch", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("badop.flag", {63'd0, bad_op}, 64'd1);
    cyc(); expect_cycle("badop.fin", 1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    cyc(); expect_cycle("badop.idle", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("badop.sticky", {63'd0, bad_op}, 64'd1);

    // Reset asserted mid-SW after byte 1: outputs drop without waiting for a clock edge.
    pulse_store(SW, 32'h0000_0400, 32'hCAFE_F00D);
    cyc(); expect_cycle("rst.b0", 1'b1, 32'h400, 8'h0D, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("rst.b1", 1'b1, 32'h401, 8'hF0, 1'b1, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    expect_cycle("rst.async", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.bad_op", {63'd0, bad_op}, 64'd0);
    cyc(); cyc();
    expect_cycle("rst.hold", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    expect_cycle("rst.nofin", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    pulse_store(SB, 32'h0000_0500, 32'h0000_007E);
    expect_cycle("post.req", 1'b0, 32'd0, 8'd0, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("post.b0", 1'b1, 32'h500, 8'h7E, 1'b1, 1'b0, 1'b1);
    cyc(); expect_cycle("post.fin", 1'b0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    cyc(); expect_cycle("post.idle", 1'b0, 32'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
